cpu_mul_sequencer: RTL and testbench

CPU_MUL_SEQUENCER -- requirements
Module: cpu_mul_sequencer

---
 rtl/mul_seq_pkg.sv | 42 ++++
 rtl/cpu_mul_sequencer_mul16_cell.sv | 28 ++
 rtl/cpu_mul_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cpu_mul_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
// Optional high-word ops are enabled by defining MUL_SEQ_HIGH_EN.
package mul_seq_pkg;

  localparam int HW     = 16;
  localparam int LAT_LO = 5;
  localparam int LAT_HI = 7;

  // last partial-product index: latency minus ACC/FIX/DONE and the issue slot
  localparam logic [1:0] LAST_LO = 2'(LAT_LO - 3);
  localparam logic [1:0] LAST_HI = 2'(LAT_HI - 4);

  typedef enum logic [1:0] {
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACC,
    S_FIX,
    S_DONE
  } state_e;

  // place a 32-bit partial product at weight 0, 16 or 32
  function automatic logic [63:0] pp_place(
    input logic [31:0] p,
    input logic [1:0]  idx
  );
    logic [63:0] r;
    unique case (idx)
      2'd0:    r = {32'b0, p};
      2'd3:    r = {p, 32'b0};
      default: r = {16'b0, p, 16'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_mul_sequencer_mul16_cell.sv
// Shared 16x16 unsigned multiplier, one registered stage.
// Synchronous clear zeroes the product register.
module mul16_cell
  import mul_seq_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic [HW-1:0] a,
  input  logic [HW-1:0] b,
  output logic [31:0]   p
);

  logic [31:0] p_d, p_q;

  // product of the current operand pair
  always_comb begin
    p_d = 32'(a) * 32'(b);
  end

  // registered product with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) p_q <= '0;
    else     p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/cpu_mul_sequencer.sv
// Sequential 32x32 multiplier built on one shared 16x16 cell.
// MUL_SEQ_HIGH_EN adds MULH/MULHSU/MULHU with sign fix-up.
module cpu_mul_sequencer
  import mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        hi_q, hi_d, neg_q, neg_d;
  logic [1:0]  cnt_q, cnt_d, iss_q, iss_d;
  logic [63:0] acc_q, acc_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [31:0] res_q, res_d;

  logic          accept;
  logic          hi_op, n1, n2;
  logic [31:0]   m1, m2;
  logic [1:0]    last_idx;
  logic [HW-1:0] ma, mb;
  logic [31:0]   pp;
  logic [63:0]   acc_sum, acc_fix;

`ifndef MUL_SEQ_HIGH_EN
  logic unused_op;
  assign unused_op = ^op;
`endif

  mul16_cell u_mul (
    .clk (clk),
    .clr (reset),
    .a   (ma),
    .b   (mb),
    .p   (pp)
  );

  // operand conditioning at acceptance
  always_comb begin
`ifdef MUL_SEQ_HIGH_EN
    hi_op = (op_e'(op) != OP_MUL);
    n1 = src1[31] && (op_e'(op) == OP_MULH ||
                      op_e'(op) == OP_MULHSU);
    n2 = src2[31] && (op_e'(op) == OP_MULH);
    m1 = n1 ? (~src1 + 32'd1) : src1;
    m2 = n2 ? (~src2 + 32'd1) : src2;
`else
    hi_op = 1'b0;
    n1 = 1'b0;
    n2 = 1'b0;
    m1 = src1;
    m2 = src2;
`endif
  end

  // half-word select for the multiplier, accumulate and sign fix
  always_comb begin
    ma = a_q[HW-1:0];
    mb = b_q[HW-1:0];
    unique case (cnt_q)
      2'd1: ma = a_q[2*HW-1:HW];
      2'd2: mb = b_q[2*HW-1:HW];
      2'd3: begin
        ma = a_q[2*HW-1:HW];
        mb = b_q[2*HW-1:HW];
      end
      default: ;
    endcase
    last_idx = hi_q ? LAST_HI : LAST_LO;
    acc_sum  = acc_q + pp_place(pp, iss_q);
    acc_fix  = neg_q ? (~acc_q + 64'd1) : acc_q;
  end

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    iss_d   = iss_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        accept  = start;
        busy_d  = start;
        state_d = start ? S_ISSUE : S_IDLE;
        if (start) begin
          a_d   = m1;
          b_d   = m2;
          hi_d  = hi_op;
          neg_d = n1 ^ n2;
          cnt_d = 2'd0;
          acc_d = '0;
        end
      end
      S_ISSUE: begin
        iss_d = cnt_q;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q != 2'd0) acc_d = acc_sum;
        if (cnt_q == last_idx) state_d = S_ACC;
      end
      S_ACC: begin
        acc_d = acc_sum;
        if (hi_q) begin
          state_d = S_FIX;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          res_d   = acc_sum[31:0];
        end
      end
      S_FIX: begin
        acc_d   = acc_fix;
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        res_d   = acc_fix[63:32];
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register; reset wins over a simultaneous start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      iss_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  logic unused_accept;
  assign unused_accept = accept;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;

endmodule

// File: tb/tb_cpu_mul_sequencer.sv
// Scoreboard bench for cpu_mul_sequencer.
// Honours MUL_SEQ_HIGH_EN the same way as the design.
module tb_cpu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        scb[$];
  exp_t        e_m;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_res = '0;

  cpu_mul_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at cyc %0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [1:0]  oo;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    oo = o;
`ifndef MUL_SEQ_HIGH_EN
    oo = 2'd0;
`endif
    case (oo)
      2'd0: begin p = ua * ub; return p[31:0]; end
      2'd1: p = sa * sb;
      2'd2: p = sa * ub;
      default: p = ua * ub;
    endcase
    return p[63:32];
  endfunction

  function automatic int lat(input logic [1:0] o);
`ifdef MUL_SEQ_HIGH_EN
    return (o == 2'd0) ? 5 : 7;
`else
    return (o == 2'd0) ? 5 : 5;
`endif
  endfunction

  // called just after a rising edge; waits for ready, strobes start once
  task automatic send(input logic [1:0] o,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input bit push);
    int n = 0;
    exp_t e;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("ready_timeout", 1, 0);
    op = o; src1 = a; src2 = b; start = 1'b1;
    e.res = model(o, a, b);
    e.cyc = cyc + lat(o);
    if (push) scb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_t1", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (scb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", scb.size(), 0);
  endtask

  // output monitor: pops expectations on done, watches result stability
  always @(negedge clk) begin
    if (reset) begin
      last_res = '0;
    end else if (done) begin
      if (scb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e_m = scb.pop_front();
        chk("result", result, e_m.res);
        chk("done_cyc", cyc, e_m.cyc);
        chk("busy_at_done", busy, 0);
      end
      last_res = result;
    end else if (result !== last_res) begin
      chk("result_hold", result, last_res);
      last_res = result;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    send(2'd0, 32'h0001_0003, 32'h0002_0004, 1'b1);
    wait_done();
    chk("mul_basic", result, 32'h000A_000C);
    @(posedge clk); #1;

    send(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    send(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    send(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(2'd1, 32'h0000_0000, 32'h8000_0000, 1'b1);
    send(2'd2, 32'h8000_0000, 32'h0000_0003, 1'b1);
    send(2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
    end
    drain();

    // start during an operation must be ignored
    @(posedge clk); #1;
    send(2'd0, 32'h1234_5678, 32'h0000_0010, 1'b1);
    @(posedge clk); #1;
    op = 2'd3; src1 = 32'hDEAD_BEEF; src2 = 32'h0BAD_F00D;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_ignored", busy, 1);
    drain();

    // start held in the DONE cycle chains a second operation
    @(posedge clk); #1;
    send(2'd0, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
    wait_done();
    send(2'd3, 32'hFFFF_0000, 32'h0001_FFFF, 1'b1);
    drain();

    // reset mid-operation aborts without a done pulse
    @(posedge clk); #1;
    send(2'd0, 32'h0000_0005, 32'h0000_0007, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    @(posedge clk); #1;
    send(2'd0, 32'h0000_0005, 32'h0000_0007, 1'b1);
    drain();
    chk("after_abort", result, 32'd35);

    repeat (10) @(posedge clk);
    #1;
    chk("pending", scb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
